// File: rtl/bi_mem_tp_pipe_pkg.sv
// Shared constants and the lane-merge helper for the bi_mem_tp_pipe memory.
// Words are widened to MAX_WIDTH so one helper serves every instance width.
package bi_mem_tp_pipe_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam RDW_NEW = "NEW";
  localparam RDW_OLD = "OLD";

  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_WIDTH        = 512;
  localparam int MAX_IDX_W        = $clog2(MAX_WIDTH);

  typedef logic [MAX_WIDTH-1:0] word_t;

  // Bit i takes data_w when its lane's mask bit is set; mask bit k covers lane k.
  function automatic word_t lane_merge(input word_t old_w, input word_t data_w,
                                       input word_t mask, input int lane);
    word_t res;
    res = old_w;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (mask[MAX_IDX_W'(i / lane)]) res[MAX_IDX_W'(i)] = data_w[MAX_IDX_W'(i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/bi_mem_tp_pipe_if.sv
// Read/write access bundle of the two-port memory; slave side is the memory.
// No flow control beyond ready_o: readValid_o is a strobe, not a handshake.
interface bi_mem_tp_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 24,
  parameter int LANE   = 8
);
  localparam int NLANES = WIDTH / LANE;
  localparam int ADDR_W = $clog2(HEIGHT);

  logic              ready_o;
  logic              readEnable_i;
  logic [ADDR_W-1:0] readAddr_i;
  logic              readValid_o;
  logic [WIDTH-1:0]  readData_o;
  logic              writeEnable_i;
  logic [ADDR_W-1:0] writeAddr_i;
  logic [NLANES-1:0] writeMask_i;
  logic [WIDTH-1:0]  writeData_i;

  modport master (
    input  ready_o, readValid_o, readData_o,
    output readEnable_i, readAddr_i, writeEnable_i, writeAddr_i, writeMask_i, writeData_i
  );

  modport slave (
    output ready_o, readValid_o, readData_o,
    input  readEnable_i, readAddr_i, writeEnable_i, writeAddr_i, writeMask_i, writeData_i
  );
endinterface

// File: rtl/bi_mem_tp_array.sv
// Register array: lane-masked synchronous write, 1-cycle registered read.
// Out-of-range reads return 0; the caller keeps writes in range. No backpressure.
module bi_mem_tp_array
  import bi_mem_tp_pipe_pkg::*;
#(
  parameter           PROFILE = "default",
  parameter int       WIDTH   = 32,
  parameter int       HEIGHT  = 24,
  parameter int       LANE    = 8,
  localparam int      NLANES  = WIDTH / LANE,
  localparam int      ADDR_W  = $clog2(HEIGHT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NLANES-1:0] wr_mask,
  input  logic [WIDTH-1:0]  wr_dat
);

  if (PROFILE != "default") begin : g_profile
    $warning("bi_mem_tp_array: PROFILE %s maps onto the generic register array", PROFILE);
  end

  logic [WIDTH-1:0] mem [HEIGHT];
  logic             rd_ok;

  assign rd_ok = {1'b0, rd_addr} < (ADDR_W+1)'(HEIGHT);

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= WIDTH'(lane_merge(word_t'(mem[wr_addr]), word_t'(wr_dat),
                                        word_t'(wr_mask), LANE));
    end
  end

  // Read samples the array before this edge's write lands: pre-write contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= rd_ok ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/bi_mem_tp_pipe.sv
// Two-port memory with lane mask, READ_LATENCY-cycle read pipeline and post-reset clear sweep.
// No backpressure: accesses are ignored while ready_o is low, reads stream one per cycle.
module bi_mem_tp_pipe
  import bi_mem_tp_pipe_pkg::*;
#(
  parameter           PROFILE        = "default",
  parameter int       WIDTH          = 32,
  parameter int       HEIGHT         = 24,
  parameter int       LANE           = 8,
  parameter int       READ_LATENCY   = 2,
  parameter           RDW_MODE       = "NEW",
  parameter int       CLEAR_ON_RESET = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bi_mem_tp_pipe_if.slave   bus
);

  localparam int NLANES  = WIDTH / LANE;
  localparam int ADDR_W  = $clog2(HEIGHT);
  localparam bit FWD_NEW = (RDW_MODE == RDW_NEW);

  if (WIDTH % LANE != 0) begin : g_chk_lane
    $error("bi_mem_tp_pipe: WIDTH must be a multiple of LANE");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_chk_lat
    $error("bi_mem_tp_pipe: READ_LATENCY must be 1..4");
  end
  if (RDW_MODE != RDW_NEW && RDW_MODE != RDW_OLD) begin : g_chk_rdw
    $error("bi_mem_tp_pipe: RDW_MODE must be NEW or OLD");
  end
  if (WIDTH > MAX_WIDTH || HEIGHT < 2) begin : g_chk_size
    $error("bi_mem_tp_pipe: unsupported WIDTH/HEIGHT");
  end

  logic [0:0]        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready, clearing;
  logic              rd_acc, wr_acc, collide;

  logic              arr_wr_en;
  logic [ADDR_W-1:0] arr_wr_addr;
  logic [NLANES-1:0] arr_wr_mask;
  logic [WIDTH-1:0]  arr_wr_dat, arr_rd_dat;

  logic              s1_vld, s1_fwd;
  logic [NLANES-1:0] s1_mask;
  logic [WIDTH-1:0]  s1_wdat, s1_dat;

  assign clearing = (state == ST_CLEAR);
  assign rd_acc   = bus.readEnable_i && ready;
  assign wr_acc   = bus.writeEnable_i && ready &&
                    ({1'b0, bus.writeAddr_i} < (ADDR_W+1)'(HEIGHT));
  assign collide  = rd_acc && wr_acc && (bus.readAddr_i == bus.writeAddr_i);

  always_comb begin
    state_nxt = state;
    if (clearing && clr_cnt == ADDR_W'(HEIGHT - 1)) state_nxt = ST_READY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == ST_READY);
      if (clearing) clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // The sweep owns the write port while clearing; user writes are gated by ready.
  assign arr_wr_en   = clearing || wr_acc;
  assign arr_wr_addr = clearing ? clr_cnt : bus.writeAddr_i;
  assign arr_wr_mask = clearing ? '1 : bus.writeMask_i;
  assign arr_wr_dat  = clearing ? '0 : bus.writeData_i;

  bi_mem_tp_array #(
    .PROFILE (PROFILE),
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .LANE    (LANE)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rd_en   (rd_acc),
    .rd_addr (bus.readAddr_i),
    .rd_dat  (arr_rd_dat),
    .wr_en   (arr_wr_en),
    .wr_addr (arr_wr_addr),
    .wr_mask (arr_wr_mask),
    .wr_dat  (arr_wr_dat)
  );

  // Colliding write captured alongside the read so stage 1 can merge it in NEW mode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      s1_fwd  <= 1'b0;
      s1_mask <= '0;
      s1_wdat <= '0;
    end else begin
      s1_vld <= rd_acc;
      if (rd_acc) begin
        s1_fwd  <= FWD_NEW && collide;
        s1_mask <= bus.writeMask_i;
        s1_wdat <= bus.writeData_i;
      end
    end
  end

  assign s1_dat = s1_fwd ? WIDTH'(lane_merge(word_t'(arr_rd_dat), word_t'(s1_wdat),
                                             word_t'(s1_mask), LANE))
                         : arr_rd_dat;

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.readValid_o = s1_vld;
    assign bus.readData_o  = s1_dat;
  end else begin : g_latn
    for (genvar k = 0; k < READ_LATENCY - 1; k++) begin : g_stage
      logic             vld, prv_vld;
      logic [WIDTH-1:0] dat, prv_dat;
      if (k == 0) begin : g_head
        assign prv_vld = s1_vld;
        assign prv_dat = s1_dat;
      end else begin : g_tail
        assign prv_vld = g_stage[k-1].vld;
        assign prv_dat = g_stage[k-1].dat;
      end
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vld <= 1'b0;
          dat <= '0;
        end else begin
          vld <= prv_vld;
          if (prv_vld) dat <= prv_dat;
        end
      end
    end
    assign bus.readValid_o = g_stage[READ_LATENCY-2].vld;
    assign bus.readData_o  = g_stage[READ_LATENCY-2].dat;
  end

  assign bus.ready_o = ready;

endmodule
